// File: rtl/counter_start_arbiter_if.sv
// Requester/counter-side bundle for counter_start_arbiter.
// master = arbiter side, slave = requesters plus counter.
interface counter_start_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned OWNER_W = 2
);
   logic [NUM_REQ-1:0] Req;
   logic               Done;
   logic               Start;
   logic [NUM_REQ-1:0] Grant;
   logic [OWNER_W-1:0] Owner;
   logic               Busy;
   logic               Timeout;

   modport master (
      input  Req, Done,
      output Start, Grant, Owner, Busy, Timeout
   );

   modport slave (
      output Req, Done,
      input  Start, Grant, Owner, Busy, Timeout
   );
endinterface

// File: rtl/counter_start_arbiter.sv
// Round-robin arbiter sharing one start/done counter among NUM_REQ requesters.
// Optional RUN watchdog compiled in with COUNTER_ARB_TIMEOUT_EN.
module counter_start_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned OWNER_W        = 2,
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input logic                      Clock,
   input logic                      Reset,
   counter_start_arbiter_if.master  bus
);

   if ((1 << OWNER_W) != NUM_REQ || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("counter_start_arbiter: inconsistent NUM_REQ/OWNER_W/TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {StIdle, StLaunch, StRun, StRelease} state_e;

   state_e             state_q;
   logic [OWNER_W-1:0] ptr_q;
   logic [OWNER_W-1:0] winner;
   logic               req_any;

   // First set request at or after the pointer; index arithmetic wraps naturally.
   always_comb begin
      logic [OWNER_W-1:0] idx;
      logic               found;
      winner = ptr_q;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ptr_q + OWNER_W'(i);
         if (!found && bus.Req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      req_any = |bus.Req;
   end

`ifdef COUNTER_ARB_TIMEOUT_EN
   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TimerW-1:0] timer_q;
   logic              expire;

   assign expire = (timer_q == TimerW'(TIMEOUT_CYCLES - 1));
`else
   assign bus.Timeout = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         bus.Start <= 1'b0;
         bus.Grant <= '0;
         bus.Owner <= '0;
         bus.Busy  <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
         timer_q     <= '0;
         bus.Timeout <= 1'b0;
`endif
      end else begin
`ifdef COUNTER_ARB_TIMEOUT_EN
         bus.Timeout <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (req_any) begin
                  state_q   <= StLaunch;
                  bus.Grant <= NUM_REQ'(1) << winner;
                  bus.Owner <= winner;
                  bus.Start <= 1'b1;
                  bus.Busy  <= 1'b1;
               end
            end
            StLaunch: begin
               bus.Start <= 1'b0;
               state_q   <= StRun;
`ifdef COUNTER_ARB_TIMEOUT_EN
               timer_q   <= '0;
`endif
            end
            StRun: begin
               // Done takes priority over a watchdog expiry on the same edge.
               if (bus.Done) begin
                  state_q   <= StRelease;
                  bus.Grant <= '0;
                  ptr_q     <= bus.Owner + OWNER_W'(1);
               end
`ifdef COUNTER_ARB_TIMEOUT_EN
               else if (expire) begin
                  state_q     <= StRelease;
                  bus.Grant   <= '0;
                  ptr_q       <= bus.Owner + OWNER_W'(1);
                  bus.Timeout <= 1'b1;
               end else begin
                  timer_q <= timer_q + TimerW'(1);
               end
`endif
            end
            StRelease: begin
               bus.Busy <= 1'b0;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_start_arbiter.sv
// Directed bench for counter_start_arbiter; expected owners queued on stimulus, popped on Start.
module tb_counter_start_arbiter;

   logic Clock = 1'b0;
   logic Reset = 1'b0;

   always #5 Clock = ~Clock;

   counter_start_arbiter_if #(.NUM_REQ(4), .OWNER_W(2)) bus ();

   counter_start_arbiter #(
      .NUM_REQ        (4),
      .OWNER_W        (2),
      .TIMEOUT_CYCLES (32)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_start = 0;
   int n_to    = 0;
   int exp_q[$];
   int s0;
   int t0;

   always @(negedge Clock) begin
      if (bus.Start === 1'b1) n_start++;
      if (bus.Timeout === 1'b1) n_to++;
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_start"}, 32'(bus.Start), 0);
      chk({tag, "_grant"}, 32'(bus.Grant), 0);
      chk({tag, "_owner"}, 32'(bus.Owner), 0);
      chk({tag, "_busy"}, 32'(bus.Busy), 0);
      chk({tag, "_timeout"}, 32'(bus.Timeout), 0);
   endtask

   // Scoreboard pop: wait (bounded) for Start, then compare against the queued owner.
   task automatic wait_start(input int budget);
      int  exp;
      bit  seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         seen = (bus.Start === 1'b1);
      end
      chk("start_seen", 32'(seen), 1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff;
      chk("sb_owner", 32'(bus.Owner), 32'(exp));
      chk("sb_grant", 32'(bus.Grant), 32'(1) << exp);
   endtask

   // Done asserted for the edge that ends the given number of cycles after Start.
   task automatic run_done(input int cycles);
      repeat (cycles - 1) step();
      bus.Done = 1'b1;
      step();
      bus.Done = 1'b0;
   endtask

   initial begin
      bus.Req  = '0;
      bus.Done = 1'b0;
      repeat (2) step();
      chk_zero("reset");
      Reset = 1'b1;
      step();

      // Single request, long run.
      exp_q.push_back(0);
      bus.Req = 4'b0001;
      wait_start(8);
      bus.Req = '0;
      step();
      chk("t2_start_once", 32'(bus.Start), 0);
      chk("t2_grant_held", 32'(bus.Grant), 32'h1);
      repeat (16) step();
      chk("t2_owner_held", 32'(bus.Owner), 0);
      bus.Done = 1'b1;
      step();
      bus.Done = 1'b0;
      chk("t2_grant_drop", 32'(bus.Grant), 0);
      chk("t2_busy_release", 32'(bus.Busy), 1);
      step();
      chk("t2_busy_low", 32'(bus.Busy), 0);
      chk("t2_owner_kept", 32'(bus.Owner), 0);

      // Async reset in the middle of a run.
      exp_q.push_back(1);
      bus.Req = 4'b0010;
      wait_start(8);
      bus.Req = '0;
      repeat (3) step();
      chk("t1_run_grant", 32'(bus.Grant), 32'h2);
      #2 Reset = 1'b0;
      #1;
      chk_zero("t1_async");
      repeat (2) step();
      Reset = 1'b1;
      step();
      chk("t1_idle", 32'(bus.Busy), 0);

      // Full contention from pointer 0.
      s0 = n_start;
      exp_q.push_back(0);
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(3);
      exp_q.push_back(0);
      bus.Req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_start(8);
         run_done(5);
      end
      bus.Req = '0;
      repeat (3) step();
      chk("t3_start_count", 32'(n_start - s0), 5);
      chk("t3_idle", 32'(bus.Busy), 0);

      // Pointer sits at 1, so 0101 grants 2 before 0.
      exp_q.push_back(2);
      exp_q.push_back(0);
      bus.Req = 4'b0101;
      wait_start(8);
      run_done(3);
      wait_start(8);
      bus.Req = '0;
      run_done(3);
      repeat (2) step();

      // Request withdrawn mid-run.
      s0 = n_start;
      exp_q.push_back(2);
      bus.Req = 4'b0100;
      wait_start(8);
      bus.Req = '0;
      repeat (10) step();
      chk("t5_grant_held", 32'(bus.Grant), 32'h4);
      chk("t5_busy", 32'(bus.Busy), 1);
      run_done(1);
      chk("t5_grant_drop", 32'(bus.Grant), 0);
      repeat (2) step();
      chk("t5_one_start", 32'(n_start - s0), 1);
      bus.Done = 1'b1;
      step();
      bus.Done = 1'b0;
      step();
      chk("t5_done_idle_busy", 32'(bus.Busy), 0);
      chk("t5_done_idle_start", 32'(n_start - s0), 1);

      // No Done: watchdog (if built) releases and hands over to requester 0.
      t0 = n_to;
      exp_q.push_back(3);
      exp_q.push_back(0);
      bus.Req = 4'b1001;
      wait_start(8);
`ifdef COUNTER_ARB_TIMEOUT_EN
      repeat (32) step();
      chk("t6_last_run_grant", 32'(bus.Grant), 32'h8);
      chk("t6_last_run_to", 32'(bus.Timeout), 0);
      step();
      chk("t6_timeout", 32'(bus.Timeout), 1);
      chk("t6_grant_drop", 32'(bus.Grant), 0);
      chk("t6_busy", 32'(bus.Busy), 1);
      step();
      chk("t6_timeout_pulse", 32'(bus.Timeout), 0);
      wait_start(4);
      bus.Req = '0;
      run_done(2);
      chk("t6_to_count", 32'(n_to - t0), 1);
`else
      repeat (40) step();
      chk("t6_still_run", 32'(bus.Grant), 32'h8);
      chk("t6_busy", 32'(bus.Busy), 1);
      chk("t6_no_timeout", 32'(n_to - t0), 0);
      run_done(1);
      chk("t6_grant_drop", 32'(bus.Grant), 0);
      wait_start(8);
      bus.Req = '0;
      run_done(2);
`endif
      repeat (3) step();
      chk("sb_drained", 32'(exp_q.size()), 0);
      chk("final_idle", 32'(bus.Busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
